// File: rtl/aud_rmm_burst.sv
// aud_rmm_burst: burst sequencer in front of a single-access RMM engine.
// It breaks one burst (addr, len, size, dir) into single accesses. Each failed
// access is re-issued up to MAX_RETRY times. Data moves through a shared FIFO:
// the host pushes it in write mode and pops it in read mode.
// Ports:
//   clk_sys_i, rmm_rst            clock, async active-high reset
//   start_i/abort_i/dir_i/size_i/addr_i/len_i   burst control
//   hwr_* / hrd_* / fifo_count_o  host FIFO push/pop ports (pop is FWFT)
//   acc_*_o / acc_*_i             request/response to the RMM engine
//   busy_o/done_o/err_o/ovf_o/und_o/remaining_o  status
module aud_rmm_burst #(
    parameter int DATA_W    = 32,
    parameter int FIFO_AW   = 4,
    parameter int LEN_W     = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk_sys_i,
    input  logic               rmm_rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               dir_i,
    input  logic [1:0]         size_i,
    input  logic [31:0]        addr_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [DATA_W-1:0]  hwr_dat_i,
    input  logic               hwr_we_i,
    output logic               hwr_full_o,
    output logic [DATA_W-1:0]  hrd_dat_o,
    input  logic               hrd_re_i,
    output logic               hrd_empty_o,
    output logic [FIFO_AW:0]   fifo_count_o,
    output logic [31:0]        acc_addr_o,
    output logic [DATA_W-1:0]  acc_dat_o,
    output logic [1:0]         acc_size_o,
    output logic               acc_we_o,
    output logic               acc_re_o,
    input  logic [DATA_W-1:0]  acc_dat_i,
    input  logic               acc_idle_i,
    input  logic               acc_err_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               ovf_o,
    output logic               und_o,
    output logic [LEN_W-1:0]   remaining_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int RW    = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q;
    logic [LEN_W-1:0]    remaining_q;
    logic                dir_q;
    logic [1:0]          size_q;
    logic [RW-1:0]       retry_q;
    logic                abort_pend_q;
    logic                err_q, ovf_q, und_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q;

    logic full, empty, misalign, bad_size, wait_first, can_issue;
    logic do_start, start_bad, do_issue, do_succ, do_retry, do_fail;
    logic eng_push, eng_pop, host_push, host_pop, push, pop, ovf_set, und_set;
    logic [DATA_W-1:0] fifo_head, push_dat;

    assign full       = (cnt_q == CW'(DEPTH));
    assign empty      = (cnt_q == '0);
    assign fifo_head  = mem[rd_ptr_q];
    assign bad_size   = (size_i == 2'b11) && (DATA_W == 32);
    // The request pulse is registered, so it is high exactly in WAIT's first cycle.
    assign wait_first = acc_we_o | acc_re_o;
    // A re-issue reuses the held data, so it does not depend on FIFO state.
    assign can_issue  = acc_idle_i && ((retry_q != '0) || (dir_q ? !empty : !full));

    always_comb begin
        misalign = 1'b0;
        case (size_i)
            2'b01:   misalign = addr_i[0];
            2'b10:   misalign = |addr_i[1:0];
            2'b11:   misalign = |addr_i[2:0];
            default: misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rmm_rst) begin
        if (rmm_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_start  = 1'b0;
        start_bad = 1'b0;
        do_issue  = 1'b0;
        do_succ   = 1'b0;
        do_retry  = 1'b0;
        do_fail   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0)              state_d = DONE;
                    else if (bad_size || misalign) start_bad = 1'b1;
                    else begin
                        do_start = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort_i) state_d = IDLE;
                else if (can_issue) begin
                    do_issue = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!wait_first && acc_idle_i) begin
                    if (abort_i || abort_pend_q) state_d = IDLE;
                    else if (acc_err_i) begin
                        if (retry_q == RW'(MAX_RETRY)) begin
                            do_fail = 1'b1;
                            state_d = IDLE;
                        end else begin
                            do_retry = 1'b1;
                            state_d  = ISSUE;
                        end
                    end else begin
                        do_succ = 1'b1;
                        state_d = (remaining_q == LEN_W'(1)) ? DONE : ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO arbitration: an engine push takes the write port, and a colliding
    // host push is then dropped and flagged like an overflow.
    assign eng_push  = do_succ & ~dir_q;
    assign eng_pop   = do_issue & dir_q & (retry_q == '0);
    assign host_push = hwr_we_i & ~full & ~eng_push;
    assign push      = host_push | (eng_push & ~full);
    assign push_dat  = eng_push ? acc_dat_i : hwr_dat_i;
    assign host_pop  = hrd_re_i & ~empty;
    assign pop       = host_pop | eng_pop;
    assign ovf_set   = (hwr_we_i & (full | eng_push)) | (eng_push & full);
    assign und_set   = hrd_re_i & empty;

    always_ff @(posedge clk_sys_i) begin
        if (push) mem[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clk_sys_i or posedge rmm_rst) begin
        if (rmm_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or posedge rmm_rst) begin
        if (rmm_rst) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            dir_q        <= 1'b0;
            size_q       <= '0;
            retry_q      <= '0;
            abort_pend_q <= 1'b0;
            acc_addr_o   <= '0;
            acc_dat_o    <= '0;
            acc_size_o   <= '0;
            acc_we_o     <= 1'b0;
            acc_re_o     <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            und_q        <= 1'b0;
        end else begin
            acc_we_o     <= do_issue & dir_q;
            acc_re_o     <= do_issue & ~dir_q;
            abort_pend_q <= (state_q == WAIT) && (state_d == WAIT) && (abort_pend_q || abort_i);
            if (do_start) begin
                addr_q      <= addr_i;
                remaining_q <= len_i;
                dir_q       <= dir_i;
                size_q      <= size_i;
                retry_q     <= '0;
            end
            if (do_issue) begin
                acc_addr_o <= addr_q;
                acc_size_o <= size_q;
                if (eng_pop) acc_dat_o <= fifo_head;
            end
            if (do_succ) begin
                addr_q      <= addr_q + (32'd1 << size_q);
                remaining_q <= remaining_q - LEN_W'(1);
                retry_q     <= '0;
            end
            if (do_retry) retry_q <= retry_q + RW'(1);

            if (start_bad || do_fail) err_q <= 1'b1;
            else if (do_start)        err_q <= 1'b0;
            if (ovf_set)              ovf_q <= 1'b1;
            else if (do_start)        ovf_q <= 1'b0;
            if (und_set)              und_q <= 1'b1;
            else if (do_start)        und_q <= 1'b0;
        end
    end

    assign hwr_full_o   = full;
    assign hrd_empty_o  = empty;
    assign hrd_dat_o    = empty ? '0 : fifo_head;
    assign fifo_count_o = cnt_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;
    assign ovf_o        = ovf_q;
    assign und_o        = und_q;
    assign remaining_o  = remaining_q;

endmodule

// File: tb/tb_aud_rmm_burst.sv
// Directed bench for aud_rmm_burst: a start-parameter table plus hand
// sequences for bursts, retries, FIFO limits, abort and reset.
module tb_aud_rmm_burst;

    localparam int DATA_W = 32;
    localparam int FIFO_AW = 4;
    localparam int LEN_W = 16;
    localparam int DEPTH = 16;

    logic clk_sys_i = 1'b0;
    logic rmm_rst = 1'b1;
    logic start_i = 1'b0, abort_i = 1'b0, dir_i = 1'b0;
    logic [1:0] size_i = '0;
    logic [31:0] addr_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic [DATA_W-1:0] hwr_dat_i = '0;
    logic hwr_we_i = 1'b0, hwr_full_o;
    logic [DATA_W-1:0] hrd_dat_o;
    logic hrd_re_i = 1'b0, hrd_empty_o;
    logic [FIFO_AW:0] fifo_count_o;
    logic [31:0] acc_addr_o;
    logic [DATA_W-1:0] acc_dat_o;
    logic [1:0] acc_size_o;
    logic acc_we_o, acc_re_o;
    logic [DATA_W-1:0] acc_dat_i = '0;
    logic acc_idle_i = 1'b1, acc_err_i = 1'b0;
    logic busy_o, done_o, err_o, ovf_o, und_o;
    logic [LEN_W-1:0] remaining_o;

    aud_rmm_burst #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .LEN_W(LEN_W), .MAX_RETRY(2)) dut (
        .clk_sys_i(clk_sys_i), .rmm_rst(rmm_rst), .start_i(start_i), .abort_i(abort_i),
        .dir_i(dir_i), .size_i(size_i), .addr_i(addr_i), .len_i(len_i),
        .hwr_dat_i(hwr_dat_i), .hwr_we_i(hwr_we_i), .hwr_full_o(hwr_full_o),
        .hrd_dat_o(hrd_dat_o), .hrd_re_i(hrd_re_i), .hrd_empty_o(hrd_empty_o),
        .fifo_count_o(fifo_count_o), .acc_addr_o(acc_addr_o), .acc_dat_o(acc_dat_o),
        .acc_size_o(acc_size_o), .acc_we_o(acc_we_o), .acc_re_o(acc_re_o),
        .acc_dat_i(acc_dat_i), .acc_idle_i(acc_idle_i), .acc_err_i(acc_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ovf_o(ovf_o), .und_o(und_o),
        .remaining_o(remaining_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    int n_tests = 0;
    int n_fail = 0;
    int n_issue = 0;
    int n_done = 0;
    int err_left = 0;
    int eng_cnt = 0;
    logic [31:0] log_addr [32];
    logic [31:0] log_dat [32];
    logic        log_we [32];

    // Engine model: busy for one cycle after each request, then idle with the
    // scripted error flag and read data D000_0000 + request index.
    always @(negedge clk_sys_i) begin
        acc_err_i = 1'b0;
        if (rmm_rst) begin
            eng_cnt = 0;
            acc_idle_i = 1'b1;
        end else if (acc_we_o || acc_re_o) begin
            if (n_issue < 32) begin
                log_addr[n_issue] = acc_addr_o;
                log_dat[n_issue] = acc_dat_o;
                log_we[n_issue] = acc_we_o;
            end
            n_issue++;
            eng_cnt = 1;
            acc_idle_i = 1'b0;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                acc_idle_i = 1'b1;
                acc_dat_i = 32'hD000_0000 + 32'(n_issue - 1);
                if (err_left > 0) begin
                    acc_err_i = 1'b1;
                    err_left--;
                end
            end
        end
    end

    always @(negedge clk_sys_i) if (done_o) n_done++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " busy"}, busy_o, 0);
        chk({tag, " done"}, done_o, 0);
        chk({tag, " err"}, err_o, 0);
        chk({tag, " ovf"}, ovf_o, 0);
        chk({tag, " und"}, und_o, 0);
        chk({tag, " we"}, acc_we_o, 0);
        chk({tag, " re"}, acc_re_o, 0);
        chk({tag, " addr"}, acc_addr_o, 0);
        chk({tag, " dat"}, acc_dat_o, 0);
        chk({tag, " size"}, acc_size_o, 0);
        chk({tag, " remaining"}, remaining_o, 0);
        chk({tag, " count"}, fifo_count_o, 0);
        chk({tag, " empty"}, hrd_empty_o, 1);
        chk({tag, " full"}, hwr_full_o, 0);
        chk({tag, " hrd_dat"}, hrd_dat_o, 0);
    endtask

    task automatic start_burst(input logic d, input logic [1:0] s, input logic [31:0] a,
                               input logic [15:0] l);
        @(negedge clk_sys_i);
        dir_i = d; size_i = s; addr_i = a; len_i = l; start_i = 1'b1;
        @(negedge clk_sys_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (busy_o && k < lim) begin
            @(negedge clk_sys_i);
            k++;
        end
        if (busy_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: busy_o still 1 after %0d cycles, want 0", lim);
        end
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys_i);
            hwr_we_i = 1'b1;
            hwr_dat_i = base + 32'(i);
        end
        @(negedge clk_sys_i);
        hwr_we_i = 1'b0;
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] exp);
        @(negedge clk_sys_i);
        chk(nm, hrd_dat_o, exp);
        hrd_re_i = 1'b1;
        @(negedge clk_sys_i);
        hrd_re_i = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        @(negedge clk_sys_i);
        while (!hrd_empty_o && k < 64) begin
            hrd_re_i = 1'b1;
            @(negedge clk_sys_i);
            k++;
        end
        hrd_re_i = 1'b0;
    endtask

    typedef struct {
        logic        dir;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [15:0] len;
        logic        exp_err;
        int          exp_done;
        int          exp_iss;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 2'b10, 32'h1000, 16'd0, 1'b0, 1, 0, 32'h0};
        vecs[1] = '{1'b1, 2'b10, 32'h1002, 16'd1, 1'b1, 0, 0, 32'h0};
        vecs[2] = '{1'b0, 2'b11, 32'h2000, 16'd1, 1'b1, 0, 0, 32'h0};
        vecs[3] = '{1'b0, 2'b01, 32'h1001, 16'd1, 1'b1, 0, 0, 32'h0};
        vecs[4] = '{1'b0, 2'b00, 32'h1003, 16'd1, 1'b0, 1, 1, 32'h1003};
        vecs[5] = '{1'b0, 2'b01, 32'h1002, 16'd2, 1'b0, 1, 2, 32'h1004};

        #3;
        chk_reset_outs("rst");
        @(negedge clk_sys_i);
        rmm_rst = 1'b0;

        // Start-parameter table
        for (int v = 0; v < 6; v++) begin
            n_issue = 0; n_done = 0;
            start_burst(vecs[v].dir, vecs[v].size, vecs[v].addr, vecs[v].len);
            wait_idle(100);
            chk($sformatf("vec%0d err", v), err_o, vecs[v].exp_err);
            chk($sformatf("vec%0d done", v), n_done, vecs[v].exp_done);
            chk($sformatf("vec%0d issues", v), n_issue, vecs[v].exp_iss);
            if (vecs[v].exp_iss > 0 && n_issue > 0)
                chk($sformatf("vec%0d last_addr", v), log_addr[n_issue-1], vecs[v].exp_last);
            drain();
        end

        // Write burst
        push_words(4, 32'hA0);
        n_issue = 0; n_done = 0;
        start_burst(1'b1, 2'b10, 32'h1000, 16'd4);
        wait_idle(200);
        chk("wr issues", n_issue, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr addr%0d", i), log_addr[i], 32'h1000 + 32'(4 * i));
            chk($sformatf("wr dat%0d", i), log_dat[i], 32'hA0 + 32'(i));
            chk($sformatf("wr we%0d", i), log_we[i], 1);
        end
        chk("wr done", n_done, 1);
        chk("wr empty", hrd_empty_o, 1);
        chk("wr count", fifo_count_o, 0);

        // Read burst with address wrap
        n_issue = 0; n_done = 0;
        start_burst(1'b0, 2'b01, 32'hFFFF_FFFC, 16'd3);
        wait_idle(200);
        chk("rd issues", n_issue, 3);
        chk("rd addr0", log_addr[0], 32'hFFFF_FFFC);
        chk("rd addr1", log_addr[1], 32'hFFFF_FFFE);
        chk("rd addr2", log_addr[2], 32'h0000_0000);
        chk("rd done", n_done, 1);
        chk("rd count", fifo_count_o, 3);
        for (int i = 0; i < 3; i++)
            pop_chk($sformatf("rd pop%0d", i), 32'hD000_0000 + 32'(i));
        chk("rd empty", hrd_empty_o, 1);

        // Retry: two errors on access 0
        push_words(2, 32'hB0);
        n_issue = 0; n_done = 0; err_left = 2;
        start_burst(1'b1, 2'b10, 32'h2000, 16'd2);
        wait_idle(200);
        chk("retry issues", n_issue, 4);
        chk("retry addr0", log_addr[0], 32'h2000);
        chk("retry addr1", log_addr[1], 32'h2000);
        chk("retry addr2", log_addr[2], 32'h2000);
        chk("retry addr3", log_addr[3], 32'h2004);
        chk("retry dat2", log_dat[2], 32'hB0);
        chk("retry dat3", log_dat[3], 32'hB1);
        chk("retry err", err_o, 0);
        chk("retry done", n_done, 1);
        chk("retry count", fifo_count_o, 0);

        // Retry exhaustion
        push_words(1, 32'hC0);
        n_issue = 0; n_done = 0; err_left = 3;
        start_burst(1'b1, 2'b10, 32'h3000, 16'd2);
        wait_idle(200);
        chk("exh issues", n_issue, 3);
        chk("exh addr2", log_addr[2], 32'h3000);
        chk("exh err", err_o, 1);
        chk("exh done", n_done, 0);
        chk("exh remaining", remaining_o, 2);

        // FIFO limits
        push_words(DEPTH + 1, 32'h100);
        chk("ovf flag", ovf_o, 1);
        chk("ovf count", fifo_count_o, DEPTH);
        chk("ovf full", hwr_full_o, 1);
        for (int i = 0; i < DEPTH - 2; i++)
            pop_chk($sformatf("ovf pop%0d", i), 32'h100 + 32'(i));
        chk("pre-simul count", fifo_count_o, 2);
        @(negedge clk_sys_i);
        hwr_we_i = 1'b1; hwr_dat_i = 32'h200; hrd_re_i = 1'b1;
        @(negedge clk_sys_i);
        hwr_we_i = 1'b0; hrd_re_i = 1'b0;
        chk("simul count", fifo_count_o, 2);
        pop_chk("simul pop0", 32'h10F);
        pop_chk("simul pop1", 32'h200);
        chk("und before", und_o, 0);
        @(negedge clk_sys_i);
        hrd_re_i = 1'b1;
        @(negedge clk_sys_i);
        hrd_re_i = 1'b0;
        chk("und flag", und_o, 1);
        chk("und count", fifo_count_o, 0);
        chk("und empty", hrd_empty_o, 1);

        // Abort while stalled in ISSUE (FIFO empty in write mode)
        n_issue = 0; n_done = 0;
        start_burst(1'b1, 2'b10, 32'h3000, 16'd1);
        @(negedge clk_sys_i);
        chk("abI busy", busy_o, 1);
        abort_i = 1'b1;
        @(negedge clk_sys_i);
        abort_i = 1'b0;
        chk("abI idle", busy_o, 0);
        chk("abI issues", n_issue, 0);
        chk("abI err", err_o, 0);
        chk("abI done", n_done, 0);

        // Abort in WAIT: the outstanding access completes, then IDLE
        push_words(3, 32'hE0);
        n_issue = 0; n_done = 0;
        start_burst(1'b1, 2'b10, 32'h4000, 16'd3);
        begin
            int k = 0;
            while (!acc_we_o && k < 50) begin
                @(negedge clk_sys_i);
                k++;
            end
        end
        chk("abW saw_we", acc_we_o, 1);
        abort_i = 1'b1;
        @(negedge clk_sys_i);
        abort_i = 1'b0;
        wait_idle(50);
        repeat (3) @(negedge clk_sys_i);
        chk("abW issues", n_issue, 1);
        chk("abW addr", log_addr[0], 32'h4000);
        chk("abW done", n_done, 0);
        chk("abW err", err_o, 0);
        chk("abW count", fifo_count_o, 2);

        // Reset mid-burst
        n_issue = 0; n_done = 0;
        start_burst(1'b1, 2'b10, 32'h5000, 16'd4);
        begin
            int k = 0;
            while (!acc_we_o && k < 50) begin
                @(negedge clk_sys_i);
                k++;
            end
        end
        @(negedge clk_sys_i);
        rmm_rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk_sys_i);
        rmm_rst = 1'b0;
        @(negedge clk_sys_i);
        chk("post-rst busy", busy_o, 0);
        chk("post-rst done", n_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aud_rmm_burst.md
AUD_RMM_BURST -- requirements
Module: aud_rmm_burst

Interface
REQ-001 Parameter DATA_W, 32, access data width; legal values 32 or 64.
REQ-002 Parameter FIFO_AW, 4, FIFO address width; depth DEPTH = 2^FIFO_AW.
REQ-003 Parameter LEN_W, 16, width of the access-count register.
REQ-004 Parameter MAX_RETRY, 2, number of re-issues allowed per failed access.
REQ-005 clk_sys_i  in  1  system clock; all logic on rising edge.
REQ-006 rmm_rst  in  1  reset, asynchronous, active-high.
REQ-007 start_i  in  1  one-cycle burst start request.
REQ-008 abort_i  in  1  abort the current burst.
REQ-009 dir_i  in  1  1 = write target memory, 0 = read target memory.
REQ-010 size_i  in  2  access size: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = 8 B.
REQ-011 addr_i  in  32  burst start address.
REQ-012 len_i  in  LEN_W  number of accesses in the burst.
REQ-013 hwr_dat_i / hwr_we_i / hwr_full_o  in DATA_W / in 1 / out 1  host FIFO push port (write mode).
REQ-014 hrd_dat_o / hrd_re_i / hrd_empty_o  out DATA_W / in 1 / out 1  host FIFO pop port (read mode); first-word-fall-through.
REQ-015 fifo_count_o  out  FIFO_AW+1  FIFO occupancy.
REQ-016 acc_addr_o / acc_dat_o / acc_size_o  out 32 / DATA_W / 2  access request to the single-access RMM engine.
REQ-017 acc_we_o / acc_re_o  out 1 / 1  one-cycle write or read request pulses.
REQ-018 acc_dat_i / acc_idle_i / acc_err_i  in DATA_W / 1 / 1  engine read data, engine idle, engine error.
REQ-019 busy_o, done_o, err_o, ovf_o, und_o  out  1 each  status outputs.
REQ-020 remaining_o  out  LEN_W  accesses still to complete.

Function
REQ-021 State machine states are IDLE, ISSUE, WAIT and DONE; any other encoding SHALL return to IDLE.
REQ-022 IDLE: start_i with len_i = 0 SHALL pulse done_o on the next cycle, with no access issued.
REQ-023 IDLE: start_i with illegal parameters SHALL set err_o and issue no access. Illegal means size 11 with DATA_W = 32, or addr_i not aligned to 2^size_i.
REQ-024 IDLE: otherwise start_i SHALL latch addr, len, dir and size, clear err_o, ovf_o and und_o, and go to ISSUE.
REQ-025 busy_o SHALL be 1 in every state except IDLE; start_i while busy_o = 1 SHALL be ignored.
REQ-026 ISSUE, write mode: when the FIFO is not empty and acc_idle_i = 1, the block SHALL pulse acc_we_o for one cycle, drive acc_dat_o from the FIFO head, pop the FIFO, and go to WAIT.
REQ-027 ISSUE, read mode: when the FIFO is not full and acc_idle_i = 1, the block SHALL pulse acc_re_o for one cycle and go to WAIT.
REQ-028 acc_addr_o, acc_size_o and acc_dat_o SHALL be registered and held stable from issue until WAIT exits.
REQ-029 WAIT SHALL ignore acc_idle_i in its first cycle.
REQ-030 WAIT SHALL exit on the first later cycle with acc_idle_i = 1, sampling acc_err_i in that cycle.
REQ-031 On an error with retry count < MAX_RETRY, the block SHALL increment the retry count and re-issue the same access from ISSUE with the held data and no FIFO pop.
REQ-032 On an error with retry count = MAX_RETRY, the block SHALL set err_o (sticky) and go to IDLE without pulsing done_o.
REQ-033 On success in read mode, acc_dat_i SHALL be pushed into the FIFO.
REQ-034 On success, the address SHALL increment by 2^size modulo 2^32, remaining_o SHALL decrement, and the retry count SHALL clear.
REQ-035 On success, the block SHALL go to DONE if remaining_o reaches 0, else to ISSUE.
REQ-036 DONE SHALL pulse done_o for exactly one cycle, then go to IDLE.
REQ-037 abort_i in ISSUE SHALL return to IDLE on the next cycle.
REQ-038 abort_i in WAIT SHALL let the outstanding access finish, discard its result, and then return to IDLE.
REQ-039 An aborted burst SHALL neither pulse done_o nor set err_o.
REQ-040 Host push with hwr_full_o = 1 SHALL be dropped and set ovf_o, even if an engine pop occurs in the same cycle.
REQ-041 Host pop with hrd_empty_o = 1 SHALL set und_o and leave FIFO state unchanged.
REQ-042 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_count_o unchanged.
REQ-043 FIFO contents SHALL persist across bursts and be cleared only by reset.
REQ-044 Latency from issue to the next issue SHALL be at least 3 cycles.

Reset
REQ-045 rmm_rst = 1 SHALL immediately force state IDLE, FIFO empty, fifo_count_o = 0, hrd_empty_o = 1, and all other outputs 0.
REQ-046 Reset mid-burst SHALL abandon the burst with no done_o pulse; the first clock edge after release SHALL see IDLE.

Verification
REQ-047 Write burst: preload 4 words, start dir = 1, size = 10, addr = 0x1000, len = 4 -> acc_we_o at 0x1000, 0x1004, 0x1008, 0x100C; one done_o pulse; FIFO empty.
REQ-048 Read burst: dir = 0, size = 01, addr = 0xFFFFFFFC, len = 3 -> addresses 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000; 3 words popped in order.
REQ-049 Retry path: acc_err_i on the first two attempts of access 0 with MAX_RETRY = 2 -> 3 issues at the same address, then continue; err_o = 0.
REQ-050 Retry exhaustion: acc_err_i on 3 attempts -> err_o = 1, no done_o, remaining_o = len.
REQ-051 Boundaries: push DEPTH + 1 words -> ovf_o = 1 and count = DEPTH; start with len = 0 -> done_o only; start with addr = 0x1002, size = 10 -> err_o = 1, no access issued.
REQ-052 Abort and reset: abort_i in WAIT -> one access completes, then IDLE with no done_o; rmm_rst asserted mid-burst -> all outputs at reset values within the same cycle.
